uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle completion pulse and stores it in a circular FIFO.
- Presents bytes to the consumer over a first-word-fall-through valid/ready interface.
- Provides occupancy, almost-full and sticky overrun status so firmware or a bus bridge can drain the FIFO without losing characters.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock
- rstN  input  1  synchronous active-low reset
- rx_data  input  8  received byte, valid only when rx_done=1
- rx_done  input  1  one-cycle pulse: rx_data is a complete byte
- m_data  output  8  head byte; 0 when m_valid=0
- m_valid  output  1  FIFO non-empty, head byte available
- m_ready  input  1  consumer accepts head byte this cycle
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AFULL_LEVEL
- overrun  output  1  sticky: at least one byte was dropped
- overrun_clr  input  1  clears overrun
- flush  input  1  synchronous empty of the FIFO

Behaviour:
- Reset is sampled on posedge clk while rstN=0. It sets wr_ptr=0, rd_ptr=0, count=0, overrun=0. Resulting outputs: m_valid=0, m_data=0, full=0, almost_full=0. Storage array contents are not reset.
- Pointer width is $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0 by natural overflow. count is a separate register with one extra bit, so full and empty are unambiguous.
- push = rx_done && (!full || pop). The byte is written at mem[wr_ptr] and wr_ptr increments.
- pop = m_valid && m_ready. rd_ptr increments.
- Occupancy update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged; this is legal at count=DEPTH and at count>=1.
- Full with a simultaneous pop: an incoming byte is accepted, because the pop frees the slot in the same cycle.
- Full without a pop: rx_done with full=1 and no pop drops the byte. Storage and pointers are unchanged, and overrun is set on the next edge.
- Empty with rx_done: there is no bypass. m_valid rises the cycle after the push edge, and m_data equals the pushed byte in that cycle. Write-to-visible latency is 1 cycle.
- Read latency is 0 (FWFT):
  - m_data = mem[rd_ptr] whenever m_valid=1.
  - After a pop edge, the next entry is visible immediately.
  - m_ready while m_valid=0 has no effect.
- m_valid = (count != 0). full and almost_full are derived combinationally from the count register, so they update in the cycle after the causing edge.
- overrun update:
  - A new drop sets overrun.
  - overrun_clr clears it.
  - If a drop and overrun_clr occur in the same cycle, set wins.
  - Overrun does not block further pushes once space frees.
- flush:
  - On the next edge, rd_ptr=wr_ptr=0 and count=0.
  - Flush has priority over push and pop in the same cycle; a byte arriving with flush is discarded and does not set overrun.
  - Flush does not clear overrun.
- Reset asserted mid-stream discards all contents. No partial state survives.
- The consumer must hold m_ready independent of m_data. The block imposes no other handshake requirement.
- rx_done is assumed to be a single-cycle pulse from the receiver. Back-to-back pulses are still handled, one byte per cycle.

Test Plan:
- Reset then idle 5 cycles -> m_valid=0, m_data=0x00, count=0, full=0, overrun=0.
- Push 0x41, 0x42, 0x43 with m_ready=0, then hold m_ready=1 -> count reaches 3; m_data sequence 0x41, 0x42, 0x43 on consecutive cycles; m_valid drops after the third pop; count returns to 0.
- Push 17 bytes 0x00..0x10 with m_ready=0 (DEPTH=16) -> full=1 after the 16th byte; 0x10 is dropped; overrun=1; almost_full=1 from count=12; draining yields 0x00..0x0F only.
- With the FIFO full, pulse rx_done=0x55 in the same cycle as a pop -> count stays 16, no overrun. The byte 0x55 is read last after draining.
- Wrap-around: push and pop 40 bytes with a random m_ready pattern and a scoreboard -> in-order data and count never exceeds 16.
- Assert overrun_clr in the same cycle as a new drop -> overrun stays 1. overrun_clr alone next cycle -> overrun=0. flush with 5 bytes queued plus a simultaneous rx_done -> count=0, m_valid=0 next cycle, overrun unchanged.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver. It captures each rx_done byte into a
// circular FIFO and presents it first-word-fall-through, with occupancy and overrun status.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overrun,
  input  logic                     overrun_clr,
  input  logic                     flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          push, pop, drop;

  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count       = count_q;
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign overrun     = overrun_q;

  always_comb begin
    pop       = m_valid && m_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the byte.
    push      = rx_done && (!full || pop);
    drop      = rx_done && full && !pop && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Set wins over clear so a drop coinciding with a clear is never lost.
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rstN && push && !flush) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [4:0] count;
  logic       full, almost_full, overrun;
  logic       overrun_clr = 1'b0;
  logic       flush = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rstN(rstN), .rx_data(rx_data), .rx_done(rx_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .full(full), .almost_full(almost_full), .overrun(overrun),
    .overrun_clr(overrun_clr), .flush(flush)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  byte unsigned mq[$];
  bit  m_ovr = 1'b0;
  bit  chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = mq.size();
    check("m_valid", m_valid, sz != 0);
    check("m_data", m_data, (sz != 0) ? mq[0] : 8'h00);
    check("count", count, sz);
    check("full", full, sz == DEPTH);
    check("almost_full", almost_full, sz >= AFULL);
    check("overrun", overrun, m_ovr);
  endtask

  // One clock: drive inputs at the falling edge, compare outputs, then advance the model.
  task automatic cyc(input bit rd, input logic [7:0] d, input bit rdy,
                     input bit clr = 1'b0, input bit fl = 1'b0, input bit rst = 1'b1);
    bit is_full, do_pop, do_push, do_drop;
    @(negedge clk);
    rstN = rst; rx_done = rd; rx_data = d; m_ready = rdy; overrun_clr = clr; flush = fl;
    if (chk_en) check_state();
    is_full = (mq.size() == DEPTH);
    do_pop  = (mq.size() != 0) && rdy;
    do_push = rd && (!is_full || do_pop);
    do_drop = rd && is_full && !do_pop;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_ovr  = 1'b0;
      chk_en = 1'b1;
    end else if (fl) begin
      mq.delete();
      if (clr) m_ovr = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(byte'(d));
      if (do_drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  endtask

  initial begin
    // Reset and idle
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0);
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_count", count, 0);

    // Three bytes, then drain
    cyc(1, 8'h41, 0);
    cyc(1, 8'h42, 0);
    cyc(1, 8'h43, 0);
    #2 check("three_count", count, 3);
    repeat (4) cyc(0, 0, 1);
    #2 check("three_empty", m_valid, 0);

    // Overfill: 17th byte dropped
    for (int i = 0; i <= 16; i++) cyc(1, 8'(i), 0);
    #2;
    check("ovf_full", full, 1);
    check("ovf_overrun", overrun, 1);
    cyc(0, 0, 0, 1);
    #2 check("ovf_clr", overrun, 0);

    // Full with simultaneous pop accepts the byte
    cyc(1, 8'h55, 1);
    #2;
    check("fullpop_count", count, 16);
    check("fullpop_overrun", overrun, 0);
    repeat (17) cyc(0, 0, 1);

    // Random traffic exercising wrap-around
    for (int i = 0; i < 80; i++)
      cyc($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
    repeat (17) cyc(0, 0, 1);

    // Drop coinciding with clear, clear alone, flush with a byte arriving
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'($urandom), 0);
    cyc(1, 8'hAA, 0, 1);
    #2 check("drop_clr_set_wins", overrun, 1);
    cyc(0, 0, 0, 1);
    #2 check("clr_alone", overrun, 0);
    cyc(1, 8'hBB, 0);
    repeat (11) cyc(0, 0, 1);
    #2 check("pre_flush_count", count, 5);
    cyc(1, 8'h77, 0, 0, 1);
    #2;
    check("flush_count", count, 0);
    check("flush_valid", m_valid, 0);
    check("flush_overrun", overrun, 1);

    // Reset mid-stream
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    check("midrst_count", count, 0);
    check("midrst_overrun", overrun, 0);
    cyc(1, 8'h33, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
